// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter that shares one single-precision multiplier between NUM_REQ
// requesters: level enable/done handshake, per-requester result return, watchdog.
module fp_mult_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int IDX_W          = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [32*NUM_REQ-1:0] dataa_flat,
   input  logic [32*NUM_REQ-1:0] datab_flat,
   output logic [NUM_REQ-1:0]    ack,
   output logic [31:0]           result,
   output logic                  err,
   output logic                  busy,
   output logic [31:0]           mult_dataa,
   output logic [31:0]           mult_datab,
   output logic                  mult_enable,
   input  logic                  mult_done,
   input  logic [31:0]           mult_result
);
   localparam int          TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    gnt_q, gnt_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                err_q, err_d;
   logic [31:0]         result_q, result_d;
   logic                mult_en_q, mult_en_d;
   logic [31:0]         opa_q, opa_d;
   logic [31:0]         opb_q, opb_d;

   logic [NUM_REQ-1:0]  req_rot;
   logic [IDX_W:0]      rot_off;
   logic [IDX_W:0]      pick_sum;
   logic [IDX_W-1:0]    pick_idx;
   logic [31:0]         pick_a, pick_b;

   // Rotate req so bit 0 is the requester just after rr_ptr; the lowest set bit wins.
   always_comb begin
      req_rot = NUM_REQ'({req, req} >> ({1'b0, rr_ptr_q} + (IDX_W+1)'(1)));
      rot_off = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_rot[j]) rot_off = (IDX_W+1)'(j);
      end
      pick_sum = {1'b0, rr_ptr_q} + rot_off + (IDX_W+1)'(1);
      if (pick_sum >= (IDX_W+1)'(NUM_REQ)) pick_sum = pick_sum - (IDX_W+1)'(NUM_REQ);
      pick_idx = IDX_W'(pick_sum);
      pick_a = '0;
      pick_b = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (pick_idx == IDX_W'(j)) begin
            pick_a = dataa_flat[32*j +: 32];
            pick_b = datab_flat[32*j +: 32];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_d     = gnt_q;
      timer_d   = timer_q;
      ack_d     = '0;
      err_d     = 1'b0;
      result_d  = result_q;
      mult_en_d = mult_en_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d     = pick_idx;
               rr_ptr_d  = pick_idx;
               opa_d     = pick_a;
               opb_d     = pick_b;
               mult_en_d = 1'b1;
               timer_d   = '0;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            timer_d = timer_q + TMR_W'(1);
            // A done arriving on the timeout edge still returns the real product.
            if (mult_done || timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               result_d  = mult_done ? mult_result : QNAN;
               err_d     = !mult_done;
               mult_en_d = 1'b0;
               state_d   = RECOVER;
               for (int j = 0; j < NUM_REQ; j++) ack_d[j] = (gnt_q == IDX_W'(j));
            end
         end
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
         gnt_q     <= '0;
         timer_q   <= '0;
         ack_q     <= '0;
         err_q     <= 1'b0;
         result_q  <= '0;
         mult_en_q <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_q     <= gnt_d;
         timer_q   <= timer_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         result_q  <= result_d;
         mult_en_q <= mult_en_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
      end
   end

   assign ack         = ack_q;
   assign err         = err_q;
   assign result      = result_q;
   assign busy        = (state_q != IDLE);
   assign mult_enable = mult_en_q;
   assign mult_dataa  = opa_q;
   assign mult_datab  = opb_q;

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Task6_Mult_top single-precision multiplier between NUM_REQ requesters.
- Replaces per-term multiplier instances in the expression pipelines; each pipeline stage issues multiplies through this block instead of owning a multiplier.
- Drives the multiplier's level enable/done handshake, returns each result to the requester that issued it, and guards against a hung unit with a watchdog.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, grant index width; must be at least clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64, maximum number of BUSY cycles before an operation is aborted.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- dataa_flat  input  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- datab_flat  input  32*NUM_REQ  operand B; same slicing as dataa_flat.
- ack  output  NUM_REQ  one-cycle pulse to the requester whose result is on result.
- result  output  32  product (IEEE-754 single); valid in the cycle ack is high and held until the next ack.
- err  output  1  high together with ack when the operation timed out.
- busy  output  1  high when state is not IDLE.
- mult_dataa  output  32  registered operand A to the multiplier.
- mult_datab  output  32  registered operand B to the multiplier.
- mult_enable  output  1  multiplier enable level.
- mult_done  input  1  multiplier done.
- mult_result  input  32  multiplier result.

Behaviour:
- Reset values: ack=0, err=0, result=0, busy=0, mult_enable=0, mult_dataa=0, mult_datab=0, state=IDLE, rr_ptr=NUM_REQ-1, timer=0.
- Reset mid-operation: the in-flight operation is discarded, no ack is issued, and mult_enable is low in the cycle after the reset edge.
- State machine: IDLE -> BUSY -> RECOVER -> IDLE.
- IDLE:
  - If any req bit is high at edge k, grant the first requester at or above rr_ptr+1, searching modulo NUM_REQ.
  - At edge k: latch that requester's operands into mult_dataa/mult_datab, store the grant index g, set rr_ptr=g, set mult_enable=1, clear timer, go to BUSY.
  - If no req bit is high, stay in IDLE.
- BUSY:
  - timer increments every cycle.
  - If mult_done=1 at edge m: result<=mult_result, ack[g]<=1, err<=0, mult_enable<=0, go to RECOVER.
  - Else if timer==TIMEOUT_CYCLES-1: result<=32'h7FC00000 (qNaN), ack[g]<=1, err<=1, mult_enable<=0, go to RECOVER.
  - If done and timeout occur on the same edge, done wins.
- RECOVER: lasts exactly one cycle; ack and err are high during this cycle and clear at the next edge; go to IDLE.
  - mult_enable is therefore low for at least 2 cycles between operations, which guarantees the multiplier re-arms.
- Back-to-back throughput: one multiply per (L+3) cycles, where L is the number of cycles from mult_enable rising to mult_done.
- Request latency: request to ack = L+2 cycles when the arbiter is idle.
- mult_done is ignored in IDLE and RECOVER.
- Requester contract:
  - Hold req and operands stable until ack.
  - Drop req in the cycle after ack, or keep it high to queue a new request; a held req is re-arbitrated under round-robin.
  - A req withdrawn before grant is simply not served.
  - Operands are sampled only at the grant edge; later changes have no effect.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 operations.
- Only one ack bit is ever high in any cycle.

Test Plan:
- Bench setup: behavioural multiplier model with L=5 that asserts done while enable is high and releases it when enable drops.
- Single request: req[2]=1, operands 0x40000000 x 0x40400000 -> mult_enable rises 1 cycle after req; ack[2] pulses 7 cycles after req; result=0x40C00000; err=0.
- Contention: req=4'b1111 held continuously, distinct operands per requester -> ack order 0,1,2,3,0; each result matches its requester's operands; consecutive acks are 8 cycles apart.
- Round-robin pointer: after serving 1, assert req=4'b0011 -> grant 0 first only if the pointer has wrapped; otherwise the next higher index. Specifically, after serving req 3, req=4'b1001 -> 0 is served before 3.
- Timeout: model never asserts done, TIMEOUT_CYCLES=64 -> ack[g]=1, err=1, result=0x7FC00000 exactly 64 cycles after the grant edge; mult_enable low during RECOVER.
- Spurious done: pulse mult_done in IDLE and in RECOVER -> no ack, state unchanged.
- Reset mid-op: assert reset 3 cycles into BUSY -> no ack, mult_enable=0, busy=0 after the reset edge; the next grant after reset goes to requester 0.
